// File: rtl/rf_writeback_unit.sv
// Register-file write-port arbiter: pipeline writeback plus a buffered long-latency source.
// Optional starvation guard enabled by defining RF_WB_STARVE_EN.
module rf_writeback_unit #(
    parameter int REG_COUNT    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int ZERO_PROTECT = 1,
    parameter int STARVE_LIMIT = 8,
    localparam int AW          = $clog2(REG_COUNT),
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  lu_valid_i,
    output logic                  lu_ready_o,
    input  logic [AW-1:0]         lu_addr_i,
    input  logic [DATA_WIDTH-1:0] lu_data_i,
    output logic                  rf_write_en_o,
    output logic [AW-1:0]         rf_write_addr_o,
    output logic [DATA_WIDTH-1:0] rf_write_data_o,
    input  logic [AW-1:0]         chk_addr_i,
    output logic                  chk_pending_o,
    output logic [CW-1:0]         count_o,
    output logic                  wb_stall_o
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("rf_writeback_unit: bad DEPTH or STARVE_LIMIT");
    end

    logic [AW-1:0]         q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]      q_live;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  ready;

    logic wb_ok;
    logic lu_ok;
    logic wb_sel;
    logic push;
    logic pop;
    logic not_empty;
    logic head_prio;

    assign count_o    = count;
    assign lu_ready_o = ready;

    // Address-0 requests are dropped here; a dropped lu request still handshakes.
    always_comb begin
        wb_ok      = wb_valid_i && !(ZERO_PROTECT != 0 && wb_addr_i == '0);
        lu_ok      = lu_valid_i && ready
                     && !(ZERO_PROTECT != 0 && lu_addr_i == '0);
        not_empty  = count != '0;
        wb_sel     = wb_ok && !head_prio;
        push       = lu_ok;
        pop        = not_empty && !wb_sel;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        logic [PW-1:0] off;
        off           = '0;
        chk_pending_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if ({1'b0, off} < count && q_live[i] && q_addr[i] == chk_addr_i)
                chk_pending_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_addr[tail] <= lu_addr_i;
            q_data[tail] <= lu_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ready           <= 1'b1;
            q_live          <= '0;
            rf_write_en_o   <= 1'b0;
            rf_write_addr_o <= '0;
            rf_write_data_o <= '0;
        end else begin
            count <= count_next;
            ready <= count_next < CW'(DEPTH);
            if (wb_sel) begin
                rf_write_en_o   <= 1'b1;
                rf_write_addr_o <= wb_addr_i;
                rf_write_data_o <= wb_data_i;
            end else if (pop) begin
                rf_write_en_o   <= q_live[head];
                rf_write_addr_o <= q_addr[head];
                rf_write_data_o <= q_data[head];
            end else begin
                rf_write_en_o   <= 1'b0;
            end
            if (pop)
                head <= head + PW'(1);
            // The pipeline result is younger: it kills any queued write to the same register.
            if (wb_sel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_addr[i] == wb_addr_i)
                        q_live[i] <= 1'b0;
                end
            end
            if (push) begin
                tail         <= tail + PW'(1);
                q_live[tail] <= !(wb_sel && lu_addr_i == wb_addr_i);
            end
        end
    end

`ifdef RF_WB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve;
    logic          stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve <= '0;
            stall  <= 1'b0;
        end else if (pop) begin
            starve <= '0;
            stall  <= 1'b0;
        end else if (not_empty && wb_ok && !stall) begin
            starve <= starve + SW'(1);
            if (starve == SW'(STARVE_LIMIT - 1))
                stall <= 1'b1;
        end
    end

    assign head_prio  = stall;
    assign wb_stall_o = stall;

    a_no_wb_during_stall: assert property (
        @(posedge clk_i) disable iff (rst_i) !(wb_valid_i && stall)
    );
`else
    assign head_prio  = 1'b0;
    assign wb_stall_o = 1'b0;
`endif

endmodule
